// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants and types for the iterative divider
//
// Contents:
//   WIDTH          default operand/result width
//   div_state_e    divider control states (IDLE/BUSY/FIXUP/DONE)
//   DIV0_QUOTIENT  quotient returned for a zero divisor (all ones)
//   cond_negate    two's-complement negate under a condition
package div_unit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

  // Used both for operand magnitudes and for result sign fixup.
  // The magnitude of -2^(WIDTH-1) comes out as 2^(WIDTH-1), which is
  // correct when the value is read as unsigned.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   rem          partial remainder before the step
//   quo          dividend/quotient shift register before the step
//   divisor_mag  unsigned divisor magnitude
//   rem_next     partial remainder after the step
//   quo_next     shift register after the step (new quotient bit in LSB)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder needs WIDTH+1 bits: with divisor_mag above
  // 2^(WIDTH-1) the remainder's top bit can be set before the shift.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;
  logic           trial_ok;

  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    // Both operands are below 2^(WIDTH+1) and rem_shift < 2*divisor_mag,
    // so a WIDTH+1 bit difference has its MSB set exactly when it is
    // negative.
    trial     = rem_shift - {1'b0, divisor_mag};
    trial_ok  = ~trial[WIDTH];
    rem_next  = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], trial_ok};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed/unsigned restoring divider with start/done handshake
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request, only looked at while idle
//   signed_op    1 = two's-complement divide, 0 = unsigned
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   busy         high from the cycle after accept until the done cycle
//   done         one-cycle pulse, results valid from this cycle
//   quotient     result, held until the next operation completes
//   remainder    result, held until the next operation completes
//   div_by_zero  set alongside done when the divisor was zero
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH_P = div_unit_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH_P-1:0] dividend,
  input  logic [WIDTH_P-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_P-1:0] quotient,
  output logic [WIDTH_P-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH_P + 1);

  div_state_e         state;
  logic [WIDTH_P-1:0] rem;
  logic [WIDTH_P-1:0] quo;
  logic [WIDTH_P-1:0] divisor_mag;
  logic [CNT_W-1:0]   count;
  logic               q_neg;
  logic               r_neg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH_P-1:0] rem_next;
  logic [WIDTH_P-1:0] quo_next;

  // Sign of each operand only matters for a signed divide.
  always_comb begin
    a_neg = signed_op & dividend[WIDTH_P-1];
    b_neg = signed_op & divisor[WIDTH_P-1];
  end

  div_step #(
    .WIDTH(WIDTH_P)
  ) u_step (
    .rem        (rem),
    .quo        (quo),
    .divisor_mag(divisor_mag),
    .rem_next   (rem_next),
    .quo_next   (quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rem         <= '0;
      quo         <= '0;
      divisor_mag <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            quo         <= cond_negate(dividend, a_neg);
            divisor_mag <= cond_negate(divisor, b_neg);
            rem         <= '0;
            count       <= CNT_W'(WIDTH_P);
            q_neg       <= a_neg ^ b_neg;
            r_neg       <= a_neg;
            busy        <= 1'b1;
            if (divisor == '0) begin
              // No iterations needed: results are fixed by definition and
              // the remainder reports the dividend exactly as supplied.
              quotient    <= DIV0_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= ST_FIXUP;
          end
        end

        ST_FIXUP: begin
          // Truncating division: quotient sign from the operand signs,
          // remainder takes the sign of the dividend.
          quotient    <= cond_negate(quo, q_neg);
          remainder   <= cond_negate(rem, r_neg);
          div_by_zero <= 1'b0;
          state       <= ST_DONE;
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  logic [31:0] prev_q;
  logic [31:0] prev_r;

  div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values, where '/' and '%'
  // truncate toward zero and the remainder follows the dividend's sign.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[31:0];
      r  = tr[31:0];
      z  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_quotient"}, quotient, 32'd0);
    check({tag, "_remainder"}, remainder, 32'd0);
    check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    int          exp_lat;
    ref_div(a, b, s, eq, er, ez);
    exp_lat = (b == 32'd0) ? 1 : 34;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, "_quotient_held"}, quotient, eq);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [31:0] ra, rb, eq, er;
    logic        rs, ez, seen_done;

    checks    = 0;
    failures  = 0;
    prev_q    = '0;
    prev_r    = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("post_reset_idle");

    // Directed cases
    run_op("u_100_7", 32'd100, 32'd7, 1'b0);
    run_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
    run_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);
    run_op("div0", 32'h1234_5678, 32'd0, 1'b0);
    run_op("s_div0", 32'h8000_0000, 32'd0, 1'b1);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("u_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("u_big_div", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    run_op("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);

    // Random operands, mixed signedness, occasional zero or small divisor
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op("rand", ra, rb, rs);
    end

    // start held high: only the IDLE-cycle starts are taken, with garbage
    // operands (including zero divisors) in every other cycle.
    for (int op = 0; op < 4; op++) begin
      ra = $urandom;
      rb = $urandom | 32'd1;
      rs = 1'($urandom_range(0, 1));
      ref_div(ra, rb, rs, eq, er, ez);
      @(negedge clk);
      start     = 1'b1;
      dividend  = ra;
      divisor   = rb;
      signed_op = rs;
      @(posedge clk);
      for (int k = 1; k <= 34; k++) begin
        @(negedge clk);
        dividend  = $urandom;
        divisor   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        signed_op = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (k < 34) begin
          check("b2b_busy", {31'd0, busy}, 32'd1);
          check("b2b_no_done", {31'd0, done}, 32'd0);
        end
        if (k <= 32) begin
          check("b2b_hold_q", quotient, prev_q);
          check("b2b_hold_r", remainder, prev_r);
        end
      end
      check("b2b_done", {31'd0, done}, 32'd1);
      check("b2b_busy_idle", {31'd0, busy}, 32'd0);
      check("b2b_quotient", quotient, eq);
      check("b2b_remainder", remainder, er);
      check("b2b_div_by_zero", {31'd0, div_by_zero}, 32'd0);
      prev_q = eq;
      prev_r = er;
    end
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of an operation
    @(negedge clk);
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'd3;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("mid_reset_no_done", {31'd0, seen_done}, 32'd0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    run_op("after_reset", 32'hFFFF_FFFF, 32'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
